// File: rtl/pipelined_reduction_tree_if.sv
// Handshake bundle for pipelined_reduction_tree: the input word set and op, and the reduced result.
// The slave modport is the reducer's view; the master modport is the producer/consumer view.
interface pipelined_reduction_tree_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned QUANTITY = 9
);
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH*QUANTITY-1:0] din;
    logic [1:0]                op;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          dout;
    logic [1:0]                out_op;

    modport master (
        output in_valid, din, op, out_ready,
        input  in_ready, out_valid, dout, out_op
    );

    modport slave (
        input  in_valid, din, op, out_ready,
        output in_ready, out_valid, dout, out_op
    );
endinterface

// File: rtl/pipelined_reduction_tree.sv
// Pipelined radix-3 OR/AND/XOR reducer with per-stage bubble collapsing.
// Optional perf counters (txn_count, stall_cycles) under PIPELINED_REDUCTION_TREE_PERF_CNT_EN.
module pipelined_reduction_tree #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned QUANTITY = 9
) (
    input  logic clk,
    input  logic rst,
    pipelined_reduction_tree_if.slave bus
`ifdef PIPELINED_REDUCTION_TREE_PERF_CNT_EN
    ,
    output logic [31:0] txn_count,
    output logic [31:0] stall_cycles
`endif
);

    function automatic int unsigned level_count(input int unsigned q);
        int unsigned n;
        int unsigned l;
        n = q;
        l = 0;
        while (n > 1) begin
            n = (n + 2) / 3;
            l = l + 1;
        end
        return (l == 0) ? 1 : l;
    endfunction

    // Number of words present at the input of tree level lvl.
    function automatic int unsigned words_at(input int unsigned q, input int unsigned lvl);
        int unsigned n;
        n = q;
        for (int unsigned i = 0; i < lvl; i++) begin
            n = (n + 2) / 3;
        end
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] combine(input logic [1:0] o,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (o)
            2'b01:   return a & b;
            2'b10:   return a ^ b;
            default: return a | b;
        endcase
    endfunction

    localparam int unsigned LEVELS = level_count(QUANTITY);

    logic [LEVELS:0]   mv_c;
    logic [LEVELS-1:0] up_v_c;
    logic [LEVELS-1:0] v_q;
    logic [LEVELS-1:0] v_d;
    logic [1:0]        op_src_c [LEVELS];
    logic [1:0]        op_q     [LEVELS];
    logic [1:0]        op_d     [LEVELS];

    // Move chain runs back from the output; an empty stage can always move.
    always_comb begin
        mv_c[LEVELS] = bus.out_ready;
        for (int i = int'(LEVELS) - 1; i >= 0; i--) begin
            mv_c[i] = ~v_q[i] | mv_c[i+1];
        end
        up_v_c[0]   = bus.in_valid;
        op_src_c[0] = bus.op;
        for (int unsigned i = 1; i < LEVELS; i++) begin
            up_v_c[i]   = v_q[i-1];
            op_src_c[i] = op_q[i-1];
        end
        for (int unsigned i = 0; i < LEVELS; i++) begin
            v_d[i]  = mv_c[i] ? up_v_c[i] : v_q[i];
            op_d[i] = (up_v_c[i] & mv_c[i]) ? op_src_c[i] : op_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q  <= '0;
            op_q <= '{default: 2'b00};
        end else begin
            v_q  <= v_d;
            op_q <= op_d;
        end
    end

    for (genvar s = 0; s < LEVELS; s++) begin : g_stage
        localparam int unsigned N_IN  = words_at(QUANTITY, s);
        localparam int unsigned N_OUT = words_at(QUANTITY, s + 1);

        logic [N_IN*WIDTH-1:0]    src_c;
        logic [3*N_OUT*WIDTH-1:0] pad_c;
        logic [N_OUT*WIDTH-1:0]   red_c;
        logic [N_OUT*WIDTH-1:0]   data_d;
        logic [N_OUT*WIDTH-1:0]   data_q;

        if (s == 0) begin : g_src_in
            assign src_c = bus.din;
        end else begin : g_src_stage
            assign src_c = g_stage[s-1].data_q;
        end

        // Incomplete last group is filled with the op's identity element.
        always_comb begin
            pad_c                  = (op_src_c[s] == 2'b01) ? '1 : '0;
            pad_c[N_IN*WIDTH-1:0]  = src_c;
            red_c                  = '0;
            for (int unsigned g = 0; g < N_OUT; g++) begin
                red_c[g*WIDTH +: WIDTH] =
                    combine(op_src_c[s],
                            combine(op_src_c[s], pad_c[(3*g)*WIDTH +: WIDTH],
                                    pad_c[(3*g+1)*WIDTH +: WIDTH]),
                            pad_c[(3*g+2)*WIDTH +: WIDTH]);
            end
            data_d = (up_v_c[s] & mv_c[s]) ? red_c : data_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end
    end

    assign bus.in_ready  = mv_c[0];
    assign bus.out_valid = v_q[LEVELS-1];
    assign bus.out_op    = op_q[LEVELS-1];
    assign bus.dout      = g_stage[LEVELS-1].data_q;

`ifdef PIPELINED_REDUCTION_TREE_PERF_CNT_EN
    logic [31:0] txn_q;
    logic [31:0] txn_d;
    logic [31:0] stall_q;
    logic [31:0] stall_d;

    always_comb begin
        txn_d   = txn_q + ((bus.in_valid & mv_c[0]) ? 32'd1 : 32'd0);
        stall_d = stall_q + ((v_q[LEVELS-1] & ~bus.out_ready) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_q   <= '0;
            stall_q <= '0;
        end else begin
            txn_q   <= txn_d;
            stall_q <= stall_d;
        end
    end

    assign txn_count    = txn_q;
    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipelined_reduction_tree.sv
// Scoreboard bench for pipelined_reduction_tree: QUANTITY=9 and QUANTITY=4 instances, WIDTH=8.
// Counter checks are compiled in when PIPELINED_REDUCTION_TREE_PERF_CNT_EN is defined.
module tb_pipelined_reduction_tree;

    localparam int LV = 2;

    typedef struct {
        logic [7:0] d;
        logic [1:0] o;
        int         cyc;
        bit         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   ov9_cnt = 0;
    exp_t q9[$];
    exp_t q4[$];

    always #5 clk = ~clk;

    pipelined_reduction_tree_if #(.WIDTH(8), .QUANTITY(9)) b9 ();
    pipelined_reduction_tree_if #(.WIDTH(8), .QUANTITY(4)) b4 ();

`ifdef PIPELINED_REDUCTION_TREE_PERF_CNT_EN
    logic [31:0] txn9, stall9, txn4, stall4;
`endif

    pipelined_reduction_tree #(.WIDTH(8), .QUANTITY(9)) u_dut9 (
        .clk (clk),
        .rst (rst),
        .bus (b9)
`ifdef PIPELINED_REDUCTION_TREE_PERF_CNT_EN
        ,
        .txn_count    (txn9),
        .stall_cycles (stall9)
`endif
    );

    pipelined_reduction_tree #(.WIDTH(8), .QUANTITY(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
`ifdef PIPELINED_REDUCTION_TREE_PERF_CNT_EN
        ,
        .txn_count    (txn4),
        .stall_cycles (stall4)
`endif
    );

    // Directed vectors: mixed back-to-back ops and the backpressure set.
    logic [71:0] mx_d [3] = '{72'h00_00_00_00_00_08_04_02_01,
                              72'hFF_FF_FF_FF_00_FF_FF_FF_FF,
                              72'h00_00_00_00_00_00_00_0A_0F};
    logic [1:0]  mx_o [3] = '{2'b00, 2'b01, 2'b10};
    logic [7:0]  mx_e [3] = '{8'h0F, 8'h00, 8'h05};

    logic [71:0] bp_d [5] = '{72'h00_00_00_00_00_00_00_22_11,
                              72'hF0_FF_FF_FF_FF_FF_FF_FF_FF,
                              72'h00_00_00_00_00_00_00_F0_0F,
                              72'h80_00_00_00_00_00_00_00_01,
                              72'h01_01_01_00_00_00_00_00_00};
    logic [1:0]  bp_o [5] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b10};
    logic [7:0]  bp_e [5] = '{8'h33, 8'hF0, 8'hFF, 8'h81, 8'h01};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitors pop the scoreboard whenever a result is handed over.
    always @(negedge clk) begin
        if (!rst && b9.out_valid) ov9_cnt++;
        if (!rst && b9.out_valid && b9.out_ready) begin
            if (q9.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL q9_unexpected: got dout 0x%0h with no pending transaction", b9.dout);
            end else begin
                exp_t e;
                e = q9.pop_front();
                chk("q9_dout", 32'(b9.dout), 32'(e.d));
                chk("q9_out_op", 32'(b9.out_op), 32'(e.o));
                if (e.lat) chk("q9_latency", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b4.out_valid && b4.out_ready) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL q4_unexpected: got dout 0x%0h with no pending transaction", b4.dout);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("q4_dout", 32'(b4.dout), 32'(e.d));
                chk("q4_out_op", 32'(b4.out_op), 32'(e.o));
                if (e.lat) chk("q4_latency", cyc, e.cyc);
            end
        end
    end

    // Drivers are entered 1 time unit after a rising edge and return at the same phase.
    task automatic send9(input logic [71:0] d, input logic [1:0] o, input logic [7:0] e, input bit lat);
        int g;
        g = 0;
        b9.din = d;
        b9.op = o;
        b9.in_valid = 1'b1;
        #1;
        while (!b9.in_ready && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (!b9.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send9_timeout: in_ready stayed 0 for %0d cycles", g);
        end else begin
            q9.push_back('{d: e, o: o, cyc: cyc + LV, lat: lat});
        end
        @(posedge clk);
        #1;
        b9.in_valid = 1'b0;
    endtask

    task automatic send4(input logic [31:0] d, input logic [1:0] o, input logic [7:0] e, input bit lat);
        int g;
        g = 0;
        b4.din = d;
        b4.op = o;
        b4.in_valid = 1'b1;
        #1;
        while (!b4.in_ready && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (!b4.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send4_timeout: in_ready stayed 0 for %0d cycles", g);
        end else begin
            q4.push_back('{d: e, o: o, cyc: cyc + LV, lat: lat});
        end
        @(posedge clk);
        #1;
        b4.in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((q9.size() != 0 || q4.size() != 0) && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain_pending", 32'(q9.size() + q4.size()), 32'd0);
    endtask

    initial begin
        int acc;
        int idx;
        int g;
        int ov_base;
        b9.in_valid = 1'b0; b9.din = '0; b9.op = 2'b00; b9.out_ready = 1'b1;
        b4.in_valid = 1'b0; b4.din = '0; b4.op = 2'b00; b4.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid9", 32'(b9.out_valid), 32'd0);
        chk("rst_dout9", 32'(b9.dout), 32'd0);
        chk("rst_out_op9", 32'(b9.out_op), 32'd0);
        chk("rst_out_valid4", 32'(b4.out_valid), 32'd0);
`ifdef PIPELINED_REDUCTION_TREE_PERF_CNT_EN
        chk("rst_txn9", txn9, 32'd0);
        chk("rst_stall9", stall9, 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        send9(72'h00_80_40_20_10_08_04_02_01, 2'b00, 8'hFF, 1'b1);
        drain();

        send4(32'hFE_F3_FF_F0, 2'b01, 8'hF0, 1'b1);
        send4(32'h0F_07_03_01, 2'b10, 8'h0A, 1'b1);
        send4(32'h80_40_20_10, 2'b00, 8'hF0, 1'b1);
        send4(32'h3C_FF_FF_FF, 2'b01, 8'h3C, 1'b1);
        send4(32'hAA_00_00_00, 2'b10, 8'hAA, 1'b1);
        drain();

        for (int i = 0; i < 3; i++) send9(mx_d[i], mx_o[i], mx_e[i], 1'b1);
        send9(72'hFF_FF_FF_FF_FF_FF_FF_FF_7F, 2'b01, 8'h7F, 1'b1);
        send9(72'h5A_5A_5A_5A_5A_5A_5A_5A_5A, 2'b10, 8'h5A, 1'b1);
        send9(72'h00_00_00_00_00_00_00_C0_03, 2'b11, 8'hC3, 1'b1);
        drain();

        b9.out_ready = 1'b0;
        acc = 0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            b9.din = bp_d[idx];
            b9.op = bp_o[idx];
            b9.in_valid = 1'b1;
            #1;
            if (b9.in_ready) begin
                q9.push_back('{d: bp_e[idx], o: bp_o[idx], cyc: 0, lat: 1'b0});
                idx++;
                acc++;
            end
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", acc, LV);
        chk("bp_in_ready", 32'(b9.in_ready), 32'd0);
        chk("bp_out_valid", 32'(b9.out_valid), 32'd1);
        chk("bp_dout_frozen", 32'(b9.dout), 32'(bp_e[0]));
        chk("bp_out_op_frozen", 32'(b9.out_op), 32'(bp_o[0]));
        b9.in_valid = 1'b0;
        b9.out_ready = 1'b1;
        for (int i = idx; i < 5; i++) send9(bp_d[i], bp_o[i], bp_e[i], 1'b0);
        drain();

        b9.out_ready = 1'b0;
        send9(72'h00_00_00_00_00_00_00_00_01, 2'b00, 8'h01, 1'b0);
        send9(72'h00_00_00_00_00_00_00_00_02, 2'b00, 8'h02, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(b9.out_valid), 32'd0);
        chk("arst_dout", 32'(b9.dout), 32'd0);
        chk("arst_out_op", 32'(b9.out_op), 32'd0);
`ifdef PIPELINED_REDUCTION_TREE_PERF_CNT_EN
        chk("arst_txn9", txn9, 32'd0);
`endif
        q9.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        b9.out_ready = 1'b1;
        ov_base = ov9_cnt;
        repeat (6) @(posedge clk);
        #1;
        chk("arst_no_stale", ov9_cnt - ov_base, 0);

`ifdef PIPELINED_REDUCTION_TREE_PERF_CNT_EN
        for (int i = 0; i < 9; i++) send9(mx_d[i%3], mx_o[i%3], mx_e[i%3], 1'b0);
        drain();
        b9.out_ready = 1'b0;
        send9(mx_d[0], mx_o[0], mx_e[0], 1'b0);
        g = 0;
        while (!b9.out_valid && g < 20) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("perf_out_valid", 32'(b9.out_valid), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        b9.out_ready = 1'b1;
        drain();
        chk("perf_txn_count", txn9, 32'd10);
        chk("perf_stall_cycles", stall9, 32'd3);
`endif

        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_reduction_tree.md
# pipelined_reduction_tree

Parametrised, pipelined large fan-in bitwise reducer that combines QUANTITY words of WIDTH bits into one word. It uses a radix-3 tree with one register level per tree level. The operation (OR, AND or XOR) is selectable per transaction. Valid/ready handshakes on both sides and per-stage bubble collapsing let it sit on a multi-cycle path in the CPU datapath, such as forwarding-select merges and wide hit-vector reduction, without limiting clock frequency.

## Interface
Parameters:
- WIDTH, 32, bits per word.
- QUANTITY, 9, number of input words; must be at least 1.
- LEVELS, derived and not overridable, number of tree levels:
  - equals ceil(log3(QUANTITY));
  - forced to 1 when QUANTITY is 1.

Ports:
- clk  in  1  clock. One clock domain: every register is clocked by clk.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input word set and op are valid.
- in_ready  out  1  block can accept the input this cycle.
- din  in  WIDTH*QUANTITY  word k occupies bits [k*WIDTH +: WIDTH].
- op  in  2  operation select: 00 OR, 01 AND, 10 XOR, 11 reserved (treated as OR).
- out_valid  out  1  dout/out_op hold a result.
- out_ready  in  1  downstream accepts the result.
- dout  out  WIDTH  reduction result.
- out_op  out  2  op that produced dout.
- txn_count  out  32  accepted-transaction count; present only with the macro.
- stall_cycles  out  32  stall-cycle count; present only with the macro.

## Operation
- Tree structure:
  - Level 0 groups the input words in threes, in index order.
  - Level i groups the level i-1 results in threes.
  - Each group's combinational result is registered at the end of the level.
- Padding:
  - A level whose word count is not a multiple of 3 pads its last group with the identity element of the op.
  - The identity is all-zeros for OR/XOR and all-ones for AND.
  - Padding never changes the result.
- op travels with its data through every stage, so transactions with different ops may be in flight at the same time.
- Each stage s has a valid bit v[s]. The last stage drives out_valid, dout and out_op.
- Stage advance rule:
  - Stage s loads when its upstream source is valid and s can move.
  - s can move when v[s] is 0, or when stage s+1 can move. For the last stage, "stage s+1 can move" means out_ready is 1.
- Bubble collapsing:
  - in_ready = stage 0 can move.
  - An empty stage accepts data even while a later stage stalls.
- A stage that does not move holds its data and op unchanged.
- Result for QUANTITY=1 is din registered once, for every op.
- Reset:
  - Clears every v[s] to 0.
  - Clears dout and out_op to 0.
  - Clears both counters to 0 when they are present.
  - Reset mid-transaction drops all in-flight data; nothing is emitted after reset releases.
- With out_valid=0, dout keeps its last value. Verification must not check dout when out_valid=0.

## Timing
- Latency: a word accepted in cycle N (in_valid & in_ready at the clock edge) appears with out_valid=1 in cycle N+LEVELS, provided there is no backpressure.
- Throughput: one transaction per cycle when out_ready is held at 1.
- Backpressure:
  - With out_ready=0 and all stages full, in_ready drops to 0 combinationally in the same cycle.
  - in_ready depends combinationally on out_ready. There is no path from in_valid to in_ready.
- Simultaneous accept and emit: with a full pipe and out_ready=1, the block accepts and emits in the same cycle with no lost or duplicated transaction.
- Output stability: dout/out_op stay stable while out_valid=1 and out_ready=0.
- No combinational path from din to dout.

## Configuration
- Macro: PIPELINED_REDUCTION_TREE_PERF_CNT_EN.
- Defined:
  - txn_count and stall_cycles ports exist.
  - txn_count increments on each in_valid & in_ready.
  - stall_cycles increments on each cycle with out_valid=1 and out_ready=0.
  - Both wrap modulo 2^32.
  - Both reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Basic OR, WIDTH=8, QUANTITY=9 (LEVELS=2):
  - Stimulus: din words 0x01,0x02,…,0x80,0x00, op=00.
  - Response: dout=0xFF, out_op=00, out_valid exactly 2 cycles after accept.
- Padding, QUANTITY=4:
  - AND of 0xF0,0xFF,0xF3,0xFE -> 0xF0.
  - XOR of 0x01,0x03,0x07,0x0F -> 0x0A.
  - Confirms identity padding of the incomplete group.
- Back-to-back mixed ops, 3 transactions with out_ready=1:
  - OR -> 0x0F, AND -> 0x00, XOR -> 0x05 on consecutive cycles.
  - out_op matches each result.
- Backpressure and bubbles, QUANTITY=9:
  - Hold out_ready=0 for 5 cycles while in_valid=1.
  - Exactly LEVELS transactions are accepted, then in_ready=0.
  - dout is frozen.
  - After release, all results drain in order with no drop or duplicate.
- Async reset mid-flight:
  - Assert rst between clock edges with 2 transactions in flight.
  - out_valid=0 and dout=0 immediately.
  - After release, no stale result appears.
  - With the macro defined, txn_count=0.
- Macro defined:
  - 10 accepts plus 3 stalled output cycles -> txn_count=10, stall_cycles=3.
